four_one_tdm_mux: RTL and testbench
===================================

Name: four_one_tdm_mux

Overview:
- Sequential 4-to-1 time-division multiplexer; transmit-side counterpart of the 1-to-4 select demultiplexer.
- Arbitrates four valid/ready input lanes onto one registered output stream. Each beat carries data plus a 2-bit channel tag (s1,s0), so a downstream 1-to-4 demux can route it back to lane a/b/c/d.
- Sits between four producer blocks and a single shared link.

Parameters:
- WIDTH, 8, data bits per lane and on the output.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a_data  input  WIDTH  lane 0 data (tag s1=0,s0=0).
- a_valid  input  1  lane 0 data valid.
- a_ready  output  1  lane 0 accepted this cycle.
- b_data / b_valid / b_ready  as lane 1 (tag 01).
- c_data / c_valid / c_ready  as lane 2 (tag 10).
- d_data / d_valid / d_ready  as lane 3 (tag 11).
- y  output  WIDTH  output data.
- s1  output  1  output channel tag MSB.
- s0  output  1  output channel tag LSB.
- y_valid  output  1  output beat valid.
- y_ready  input  1  downstream accepts beat.
- xfer_cnt  output  CNT_W  count of beats accepted from inputs.

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset values: y=0, s1=0, s0=0, y_valid=0, xfer_cnt=0, round-robin pointer ptr=0 (lane a).
- Output stage is a one-entry register (y, s1, s0, y_valid).
  - load_ok = !y_valid || y_ready.
- Grant (combinational):
  - Search lanes starting at ptr, wrapping 3->0.
  - The first lane with valid=1 is granted.
  - If no lane is valid, there is no grant.
- Ready: only the granted lane's *_ready = load_ok. All other readies are 0. Readies never depend on their own lane's valid except through the grant.
- Transfer on lane N when N_valid && N_ready. On that clock edge:
  - y <= N_data
  - {s1,s0} <= N
  - y_valid <= 1
  - ptr <= (N+1) mod 4
  - xfer_cnt <= xfer_cnt+1
- xfer_cnt wraps from all-ones to 0 silently.
- No transfer but y_ready && y_valid: y_valid <= 0. y, s1 and s0 hold their last value.
- No transfer and y_valid && !y_ready: all output registers hold (backpressure). Inputs see ready=0.
- Simultaneous drain and load: when the output is consumed and a new lane is granted in the same cycle, the new beat loads with y_valid staying 1. This gives full throughput of one beat per cycle.
- Latency: an input accepted at edge k appears on y/s1/s0 with y_valid=1 after edge k (one cycle).
- Fairness: with all four lanes continuously valid and y_ready=1, the output tag sequence is 00,01,10,11,00,...
- ptr advances only on a transfer, never on an idle cycle.
- Reset mid-operation: any held beat is discarded (y_valid=0), ptr returns to 0, and all readies drop to 0 in the reset cycle.
- No combinational path from y_ready to y/s1/s0. There is a combinational path y_ready -> *_ready (permitted).

Optional Feature:
- Macro FIXED_PRIORITY_EN.
- Defined: grant search always starts at lane a, giving priority a>b>c>d. ptr is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: assert rst for 2 cycles with all lanes valid -> all readies 0 during reset. Afterwards y_valid=0, xfer_cnt=0, first grant goes to lane a.
- Single lane: c_data=8'h5A, c_valid=1 for one beat, y_ready=1 -> c_ready=1 in cycle k. At k+1: y=8'h5A, s1=1, s0=0, y_valid=1. xfer_cnt=1.
- Round-robin: all lanes valid, data a=11,b=22,c=33,d=44, y_ready=1 -> output beats 11/00, 22/01, 33/10, 44/11, 11/00, one per cycle. Under FIXED_PRIORITY_EN, all beats are 11/00.
- Backpressure: hold y_ready=0 for 3 cycles with beat 22/01 pending -> y/s1/s0 stable, all *_ready=0, ptr unchanged. Release y_ready -> the next lane is granted the same cycle.
- Counter wrap: CNT_W=8, send 256 beats -> xfer_cnt returns to 0.
- Reset mid-stream: assert rst while y_valid=1 with y_ready=0 -> y_valid=0 next cycle. The held beat is never presented, and the next grant is lane a.

Source files
------------

// File: rtl/four_one_tdm_mux_if.sv
// Bundle of the four producer lanes and the shared output link of four_one_tdm_mux.
// The master side drives lane data/valid and y_ready; the slave side is the mux.
interface four_one_tdm_mux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] c_data;
    logic             c_valid;
    logic             c_ready;
    logic [WIDTH-1:0] d_data;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y;
    logic             s1;
    logic             s0;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output a_data, a_valid, b_data, b_valid, c_data, c_valid, d_data, d_valid, y_ready,
        input  a_ready, b_ready, c_ready, d_ready, y, s1, s0, y_valid
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, c_data, c_valid, d_data, d_valid, y_ready,
        output a_ready, b_ready, c_ready, d_ready, y, s1, s0, y_valid
    );
endinterface

// File: rtl/four_one_tdm_mux.sv
// 4-to-1 TDM mux: round-robin arbitration of four valid/ready lanes onto one registered,
// channel-tagged output beat. Define FIXED_PRIORITY_EN for fixed a>b>c>d priority instead.
module four_one_tdm_mux #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    four_one_tdm_mux_if.slave bus,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic [3:0]       lane_valid;
    logic [WIDTH-1:0] lane_data [4];
    logic [3:0]       lane_ready;

    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       tag_q, tag_d;
    logic             y_valid_q, y_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       start;
    logic [1:0]       cand;
    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic             load_ok;
    logic             xfer;

    assign lane_valid   = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
    assign lane_data[0] = bus.a_data;
    assign lane_data[1] = bus.b_data;
    assign lane_data[2] = bus.c_data;
    assign lane_data[3] = bus.d_data;

`ifdef FIXED_PRIORITY_EN
    assign start = '0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = gnt_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // First valid lane at or after start, wrapping 3->0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = start + i[1:0];
            if (!gnt_found && lane_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // rst gates the grant so all readies drop in the reset cycle itself.
    assign load_ok = !y_valid_q || bus.y_ready;
    assign xfer    = gnt_found && load_ok && !rst;

    always_comb begin
        lane_ready = '0;
        if (xfer) lane_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        y_d       = y_q;
        tag_d     = tag_q;
        y_valid_d = y_valid_q;
        cnt_d     = cnt_q;
        if (xfer) begin
            y_d       = lane_data[gnt_idx];
            tag_d     = gnt_idx;
            y_valid_d = 1'b1;
            cnt_d     = cnt_q + 1'b1;
        end else if (bus.y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            tag_q     <= '0;
            y_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            y_q       <= y_d;
            tag_q     <= tag_d;
            y_valid_q <= y_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.a_ready = lane_ready[0];
    assign bus.b_ready = lane_ready[1];
    assign bus.c_ready = lane_ready[2];
    assign bus.d_ready = lane_ready[3];
    assign bus.y       = y_q;
    assign bus.s1      = tag_q[1];
    assign bus.s0      = tag_q[0];
    assign bus.y_valid = y_valid_q;
    assign xfer_cnt    = cnt_q;
endmodule

// File: tb/tb_four_one_tdm_mux.sv
// Directed-vector bench for four_one_tdm_mux; expectations follow FIXED_PRIORITY_EN if defined.
module tb_four_one_tdm_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] xfer_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    four_one_tdm_mux_if #(.WIDTH(8)) bus ();

    four_one_tdm_mux #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid} = v;
    endtask

    function automatic logic [3:0] readies();
        return {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    endfunction

    task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] t, input logic v);
        check({tag, "_y"},  {24'h0, bus.y}, {24'h0, d});
        check({tag, "_s"},  {30'h0, bus.s1, bus.s0}, {30'h0, t});
        check({tag, "_yv"}, {31'h0, bus.y_valid}, {31'h0, v});
    endtask

    logic [7:0] rr_data [5];
    logic [1:0] rr_tag  [5];

    initial begin
        rst         = 1'b1;
        bus.a_data  = 8'h11;
        bus.b_data  = 8'h22;
        bus.c_data  = 8'h33;
        bus.d_data  = 8'h44;
        bus.y_ready = 1'b1;
        set_valid(4'b1111);

        // Reset for two cycles with every lane valid
        for (int i = 0; i < 2; i++) begin
            #2;
            check("rst_rdy", {28'h0, readies()}, 32'h0);
            tick();
        end
        rst = 1'b0;
        #2;
        check("rst_yv", {31'h0, bus.y_valid}, 32'h0);
        check("rst_cnt", {24'h0, xfer_cnt}, 32'h0);
        check("first_gnt", {28'h0, readies()}, 32'h1);

        // Round-robin, one beat per cycle
`ifdef FIXED_PRIORITY_EN
        rr_data = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        rr_tag  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        rr_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        rr_tag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("rr%0d", i), rr_data[i], rr_tag[i], 1'b1);
        end
        check("rr_cnt", {24'h0, xfer_cnt}, 32'd5);

        // Drain: held data stays, y_valid drops
        set_valid(4'b0000);
        tick();
        check_out("drain", rr_data[4], rr_tag[4], 1'b0);

        // Single beat on lane c
        bus.c_data = 8'h5A;
        set_valid(4'b0100);
        #2;
        check("c_rdy", {28'h0, readies()}, 32'h4);
        tick();
        set_valid(4'b0000);
        check_out("single", 8'h5A, 2'd2, 1'b1);
        check("single_cnt", {24'h0, xfer_cnt}, 32'd6);

        // Load 22/01 while the 5A beat drains in the same cycle
        bus.c_data = 8'h33;
        set_valid(4'b0010);
        tick();
        check_out("b_load", 8'h22, 2'd1, 1'b1);

        // Backpressure for three cycles
        bus.y_ready = 1'b0;
        set_valid(4'b1111);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_rdy", {28'h0, readies()}, 32'h0);
            tick();
            check_out($sformatf("bp%0d", i), 8'h22, 2'd1, 1'b1);
            check("bp_cnt", {24'h0, xfer_cnt}, 32'd7);
        end
        bus.y_ready = 1'b1;
        #2;
`ifdef FIXED_PRIORITY_EN
        check("release_gnt", {28'h0, readies()}, 32'h1);
        tick();
        check_out("release", 8'h11, 2'd0, 1'b1);
`else
        check("release_gnt", {28'h0, readies()}, 32'h4);
        tick();
        check_out("release", 8'h33, 2'd2, 1'b1);
`endif
        check("release_cnt", {24'h0, xfer_cnt}, 32'd8);

        // Reset while a beat is held under backpressure
        bus.y_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("mid_rst_rdy", {28'h0, readies()}, 32'h0);
        tick();
        rst = 1'b0;
        #2;
        check("mid_rst_yv", {31'h0, bus.y_valid}, 32'h0);
        check("mid_rst_cnt", {24'h0, xfer_cnt}, 32'h0);
        check("mid_rst_gnt", {28'h0, readies()}, 32'h1);
        tick();
        check_out("post_rst", 8'h11, 2'd0, 1'b1);

        // Counter wrap: 255 more beats on lane d takes 1 -> 256 == 0
        bus.y_ready = 1'b1;
        set_valid(4'b1000);
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 254) check("cnt_ff", {24'h0, xfer_cnt}, 32'hFF);
        end
        check_out("wrap", 8'h44, 2'd3, 1'b1);
        check("cnt_wrap", {24'h0, xfer_cnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
